// File: rtl/dem_seq_ctrl.sv
// Run sequencer for the 8-bit DEM up/down counter: clear, up to TOP, pause, down to 0, pause, per speed.
// Optional SEQ_LOOP_EN: restart from speed 1 after each completed run until stop.
module dem_seq_ctrl #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned LAST_SPEED = 3,
  parameter logic [7:0]  TOP        = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] led,
  output logic [1:0] sw,
  output logic       ud,
  output logic       cnt_rst,
  output logic       busy,
  output logic [2:0] phase,
  output logic       done
);

  localparam int unsigned HOLD_W = 26;
  localparam int unsigned SPD_W  = 2;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [SPD_W-1:0]  SPD_LAST  = SPD_W'(LAST_SPEED);
  localparam logic [SPD_W-1:0]  SPD_FIRST = SPD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_UP     = 3'd2,
    S_HOLD_T = 3'd3,
    S_DOWN   = 3'd4,
    S_HOLD_B = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [SPD_W-1:0]    spd_q, spd_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                clr_q, clr_d;

  logic [SPD_W-1:0]    sw_d;
  logic                ud_d, cnt_rst_d, busy_d, done_d;

  // State, speed, pause and clear-length registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      spd_q   <= SPD_FIRST;
      hold_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      hold_q  <= hold_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state logic; stop overrides every transition
  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    hold_d  = hold_q;
    clr_d   = clr_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLEAR;
            spd_d   = SPD_FIRST;
            clr_d   = 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_q) state_d = S_UP;
          else       clr_d   = 1'b1;
        end
        S_UP: begin
          if (led == TOP) begin
            state_d = S_HOLD_T;
            hold_d  = '0;
          end
        end
        S_HOLD_T: begin
          if (hold_q == HOLD_LAST) state_d = S_DOWN;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
        S_DOWN: begin
          if (led == 8'h00) begin
            if (spd_q == SPD_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_HOLD_B;
              spd_d   = spd_q + SPD_W'(1);
              hold_d  = '0;
            end
          end
        end
        S_HOLD_B: begin
          if (hold_q == HOLD_LAST) state_d = S_UP;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
        S_DONE: begin
`ifdef SEQ_LOOP_EN
          state_d = S_CLEAR;
          spd_d   = SPD_FIRST;
          clr_d   = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with phase
  always_comb begin
    sw_d      = '0;
    ud_d      = 1'b1;
    cnt_rst_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        cnt_rst_d = 1'b1;
        busy_d    = 1'b0;
      end
      S_CLEAR:  cnt_rst_d = 1'b1;
      S_UP:     sw_d      = spd_d;
      S_HOLD_T: ud_d      = 1'b1;
      S_DOWN: begin
        sw_d = spd_d;
        ud_d = 1'b0;
      end
      S_HOLD_B: ud_d = 1'b0;
      S_DONE: begin
        done_d    = 1'b1;
        cnt_rst_d = 1'b1;
      end
      default: begin
        cnt_rst_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw      <= '0;
      ud      <= 1'b1;
      cnt_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sw      <= sw_d;
      ud      <= ud_d;
      cnt_rst <= cnt_rst_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_dem_seq_ctrl.sv
// Scoreboard bench for dem_seq_ctrl with a behavioural DEM counter on the led feedback.
// Covers both builds; the looping checks run only when SEQ_LOOP_EN is defined.
module tb_dem_seq_ctrl;

  localparam int unsigned HOLD = 4;
  localparam int unsigned LAST = 3;
  localparam logic [7:0]  TOPV = 8'h0F;

  // Tuple layout: {phase[2:0], sw[1:0], ud, cnt_rst, busy, done}
  localparam logic [8:0] ALL     = 9'h1FF;
  localparam logic [8:0] NO_UD   = 9'b111_11_0_111;
  localparam logic [8:0] T_IDLE  = {3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [8:0] T_CLEAR = {3'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [8:0] T_HOLDT = {3'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [8:0] T_HOLDB = {3'd5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [8:0] T_DONE  = {3'd6, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1};

  typedef struct packed {
    logic [8:0] val;
    logic [8:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] led = 8'h00;
  logic [1:0] sw;
  logic       ud, cnt_rst, busy, done;
  logic [2:0] phase;
  logic [8:0] obs;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dem_seq_ctrl #(.HOLD_CYC(HOLD), .LAST_SPEED(LAST), .TOP(TOPV)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .led(led),
    .sw(sw), .ud(ud), .cnt_rst(cnt_rst), .busy(busy), .phase(phase), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {phase, sw, ud, cnt_rst, busy, done};

  // DEM counter: synchronous clear, one step per cycle while sw != 0
  always @(posedge clk) begin
    if (cnt_rst)        led <= 8'h00;
    else if (sw != 2'd0) led <= ud ? led + 8'd1 : led - 8'd1;
  end

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [8:0] v, input logic [8:0] m, input int n);
    exp_t e;
    e.val  = v;
    e.mask = m;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // Expected trace of one pass, following the DEM value through each segment
  task automatic push_pass();
    logic [7:0] l;
    logic [7:0] d;
    l = 8'h00;
    push(T_CLEAR, ALL, 2);
    for (int s = 1; s <= int'(LAST); s++) begin
      d = TOPV - l;
      push({3'd2, 2'(s), 1'b1, 1'b0, 1'b1, 1'b0}, ALL, int'(d) + 1);
      l = TOPV + 8'd1;
      push(T_HOLDT, ALL, int'(HOLD));
      push({3'd4, 2'(s), 1'b0, 1'b0, 1'b1, 1'b0}, ALL, int'(l) + 1);
      l = 8'hFF;
      if (s < int'(LAST)) push(T_HOLDB, NO_UD, int'(HOLD));
    end
    push(T_DONE, ALL, 1);
  endtask

  // Compare one queued expectation per cycle, just after the edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check($sformatf("trace_ph%0d", mon_e.val[8:6]), obs & mon_e.mask, mon_e.val & mon_e.mask);
    end
  end

  task automatic wait_drain(input string tag, input int lim);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, 9'(sb_q.size()), 9'd0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] ph, input bit use_led,
                            input logic [7:0] lv);
    int k;
    k = 0;
    while (!(phase == ph && (!use_led || led == lv)) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check(tag, {6'd0, phase}, {6'd0, ph});
  endtask

  task automatic finish_run(input string tag);
`ifdef SEQ_LOOP_EN
    stop = 1'b1;
    push(T_IDLE, ALL, 1);
    @(negedge clk);
    stop = 1'b0;
    wait_drain({tag, "_stop"}, 10);
`else
    wait_drain({tag, "_idle"}, 4);
`endif
  endtask

  initial begin
    // Reset values, then quiet idle
    repeat (3) @(negedge clk);
    check("reset_vals", obs, T_IDLE);
    reset = 1'b1;
    push(T_IDLE, ALL, 100);
    wait_drain("idle100", 200);

    // Full run through all speeds
    start = 1'b1;
    push_pass();
`ifndef SEQ_LOOP_EN
    push(T_IDLE, ALL, 1);
`endif
    @(negedge clk);
    start = 1'b0;
    wait_drain("full_run", 400);
    finish_run("full_run");

    // stop beats start in IDLE
    start = 1'b1;
    stop  = 1'b1;
    push(T_IDLE, ALL, 1);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    wait_drain("prio", 10);

    // start while busy (in UP, then in HOLD_T) leaves the run untouched
    start = 1'b1;
    push_pass();
`ifndef SEQ_LOOP_EN
    push(T_IDLE, ALL, 1);
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("reach_hold_t", 3'd3, 1'b0, 8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("busy_start", 400);
    finish_run("busy_start");

    // Abort in DOWN at led=07
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("reach_down7", 3'd4, 1'b1, 8'h07);
    stop = 1'b1;
    push(T_IDLE, ALL, 1);
    @(negedge clk);
    stop = 1'b0;
    wait_drain("abort", 10);

    // Asynchronous reset between edges during HOLD_T
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("reach_hold_t2", 3'd3, 1'b0, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", obs, T_IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset", obs, T_IDLE);

`ifdef SEQ_LOOP_EN
    // Two back-to-back passes, busy held throughout, then stop
    start = 1'b1;
    push_pass();
    push_pass();
    @(negedge clk);
    start = 1'b0;
    wait_drain("loop2", 600);
    stop = 1'b1;
    push(T_IDLE, ALL, 1);
    @(negedge clk);
    stop = 1'b0;
    wait_drain("loop_stop", 10);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
